// File: rtl/uart_pkg.sv
// Shared types for the buffered UART receiver: parity modes, FSM states,
// the received-word record and small helpers used by the receiver datapath.
package uart_pkg;

  localparam int MAX_DW = 9;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'd0,
    PAR_EVEN     = 2'd1,
    PAR_ODD      = 2'd2,
    PAR_NONE_ALT = 2'd3
  } parity_mode_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  typedef struct packed {
    logic [MAX_DW-1:0] data;
    logic              parity_err;
    logic              frame_err;
  } rx_word_t;

  function automatic int calc_div(
    input int clk_hz,
    input int baud,
    input int os
  );
    int d;
    d = clk_hz / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_buffered_fifo.sv
// sync_fifo: single-clock FIFO, push strobe in, valid/ready pop out.
// Ports: clk, rst, push, push_data, pop_ready, pop_valid, pop_data, full, count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_ready,
  output logic                     pop_valid,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign pop_valid = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop_valid && pop_ready;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push   = push && (!full || do_pop);
  assign pop_data  = pop_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// Oversampling UART receiver with parity/stop checks feeding a sync_fifo.
// Ports: clk, rst, rx, parity_mode, two_stop -> m_data/m_parity_err/
// m_frame_err/m_valid (m_ready pops), overrun, break_det, fifo_count.
// Macro UART_RX_BREAK_DETECT_EN enables line-break detection.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_parity_err,
  output logic                          m_frame_err,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          overrun,
  output logic                          break_det,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = calc_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int DCW = $clog2(DIV + 1);
  localparam int TCW = $clog2(OVERSAMPLE);
  localparam int FW  = DATA_WIDTH + 2;

  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [TCW-1:0] T_S0     = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] T_S1     = TCW'(OVERSAMPLE / 2);
  localparam logic [TCW-1:0] T_DEC    = TCW'(OVERSAMPLE / 2 + 1);
  localparam logic [TCW-1:0] T_END    = TCW'(OVERSAMPLE - 1);
  localparam logic [3:0]     LAST_BIT = 4'(DATA_WIDTH - 1);

  rx_state_t state;
  rx_state_t state_n;

  logic                  rx_meta;
  logic                  rx_sync;
  logic                  rx_prev;
  logic [1:0]            warm;
  logic                  start_edge;

  logic [DCW-1:0]        div_cnt;
  logic                  tick;
  logic [TCW-1:0]        tick_cnt;
  logic [3:0]            bit_cnt;
  logic                  stop_idx;
  logic                  s0;
  logic                  s1;
  logic [DATA_WIDTH-1:0] sh;
  logic                  pbit;
  logic                  ferr;
  parity_mode_t          par_q;
  logic                  two_q;

  logic                  maj;
  logic                  at_s0;
  logic                  at_s1;
  logic                  at_dec;
  logic                  at_end;
  logic                  par_en;
  logic                  last_bit;
  logic                  last_stop;
  logic                  ferr_now;
  logic                  perr_now;
  logic                  is_brk;
  logic                  push;
  logic                  brk;

  rx_word_t              word;
  logic                  word_unused;
  logic [FW-1:0]         fifo_din;
  logic [FW-1:0]         fifo_dout;
  logic                  fifo_full;

  // warm keeps edge detection off until the synchroniser holds real
  // line samples, so only a falling edge seen after reset starts a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b0;
      warm    <= 2'b00;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= warm[1] ? rx_sync : 1'b0;
      warm    <= {warm[0], 1'b1};
    end
  end

  assign start_edge = (state == IDLE) && rx_prev && !rx_sync;
  assign tick       = (div_cnt == DIV_LAST);

  assign maj       = maj3(s0, s1, rx_sync);
  assign at_s0     = tick && (tick_cnt == T_S0);
  assign at_s1     = tick && (tick_cnt == T_S1);
  assign at_dec    = tick && (tick_cnt == T_DEC);
  assign at_end    = tick && (tick_cnt == T_END);
  assign par_en    = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
  assign last_bit  = (bit_cnt == LAST_BIT);
  assign last_stop = !two_q || stop_idx;
  assign ferr_now  = ferr | !maj;

  always_comb begin
    perr_now = 1'b0;
    unique case (1'b1)
      par_q == PAR_EVEN: perr_now = (pbit != ^sh);
      par_q == PAR_ODD:  perr_now = (pbit != ~^sh);
      default:           perr_now = 1'b0;
    endcase
  end

`ifdef UART_RX_BREAK_DETECT_EN
  assign is_brk = (sh == '0) && (!par_en || !pbit) && ferr_now;
`else
  assign is_brk = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // The last stop bit is resolved at its mid-bit decision, leaving half a
  // bit of margin to catch the next start edge.
  always_comb begin
    state_n = state;
    push    = 1'b0;
    brk     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_edge) state_n = START;
      end
      START: begin
        if (at_dec && maj)  state_n = IDLE;
        else if (at_end)    state_n = DATA;
      end
      DATA: begin
        if (at_end && last_bit)
          state_n = par_en ? PARITY : STOP;
      end
      PARITY: begin
        if (at_end) state_n = STOP;
      end
      STOP: begin
        if (at_dec && last_stop) begin
          state_n = IDLE;
          if (is_brk) brk  = 1'b1;
          else        push = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      stop_idx <= 1'b0;
      s0       <= 1'b1;
      s1       <= 1'b1;
      sh       <= '0;
      pbit     <= 1'b0;
      ferr     <= 1'b0;
      par_q    <= PAR_NONE;
      two_q    <= 1'b0;
    end else begin
      if (start_edge || tick) div_cnt <= '0;
      else                    div_cnt <= div_cnt + 1'b1;

      if (state == IDLE) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
        stop_idx <= 1'b0;
        ferr     <= 1'b0;
        par_q    <= parity_mode_t'(parity_mode);
        two_q    <= two_stop;
      end else if (tick) begin
        tick_cnt <= at_end ? '0 : tick_cnt + 1'b1;
        if (at_s0) s0 <= rx_sync;
        if (at_s1) s1 <= rx_sync;
        if (at_dec) begin
          case (state)
            DATA:    sh   <= {maj, sh[DATA_WIDTH-1:1]};
            PARITY:  pbit <= maj;
            STOP:    ferr <= ferr_now;
            default: ;
          endcase
        end
        if (at_end && state == DATA) bit_cnt  <= bit_cnt + 1'b1;
        if (at_end && state == STOP) stop_idx <= 1'b1;
      end
    end
  end

  always_comb begin
    word                       = '0;
    word.data[DATA_WIDTH-1:0]  = sh;
    word.parity_err            = perr_now;
    word.frame_err             = ferr_now;
  end

  assign word_unused = ^word.data;
  assign fifo_din    = {word.data[DATA_WIDTH-1:0],
                        word.parity_err,
                        word.frame_err};

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fifo_din),
    .pop_ready (m_ready),
    .pop_valid (m_valid),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign m_data       = fifo_dout[FW-1:2];
  assign m_parity_err = fifo_dout[1];
  assign m_frame_err  = fifo_dout[0];
  assign overrun      = push && fifo_full && !(m_valid && m_ready);
  assign break_det    = brk;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered: directed frames, queued
// expectations, monitor pops and compares on every accepted word.
module tb_uart_rx_buffered;

  localparam int DW  = 8;
  localparam int FD  = 4;
  localparam int BIT = 160;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic [1:0]    parity_mode = 2'd0;
  logic          two_stop = 1'b0;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_parity_err;
  logic          m_frame_err;
  logic          m_valid;
  logic          overrun;
  logic          break_det;
  logic [2:0]    fifo_count;

  uart_rx_buffered #(
    .DATA_WIDTH (DW),
    .CLOCK_FREQ (1_600_000),
    .BAUD_RATE  (10_000),
    .OVERSAMPLE (16),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .parity_mode  (parity_mode),
    .two_stop     (two_stop),
    .m_data       (m_data),
    .m_parity_err (m_parity_err),
    .m_frame_err  (m_frame_err),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .overrun      (overrun),
    .break_det    (break_det),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         rise_cyc = -1;
  int         ovr_cnt = 0;
  int         brk_cnt = 0;
  logic       prev_valid = 1'b0;
  logic [9:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (overrun === 1'b1)   ovr_cnt++;
        if (break_det === 1'b1) brk_cnt++;
        if (m_valid === 1'b1 && !prev_valid) rise_cyc = cyc;
        prev_valid = (m_valid === 1'b1);
        if (m_valid === 1'b1 && m_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL pop: unexpected word 0x%0h", m_data);
          end else begin
            check("pop", {m_data, m_parity_err, m_frame_err},
                  exp_q.pop_front());
          end
        end
      end
    end
  end

  function automatic logic [15:0] fr(input logic [7:0] d,
                                     input bit par,
                                     input logic pb,
                                     input logic st1,
                                     input logic st2);
    logic [15:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (par) begin
      f[9]  = pb;
      f[10] = st1;
      f[11] = st2;
    end else begin
      f[9]  = st1;
      f[10] = st2;
    end
    return f;
  endfunction

  task automatic send(input logic [15:0] bits,
                      input int nbits,
                      input int pulse_at);
    for (int i = 0; i < nbits * BIT; i++) begin
      @(negedge clk);
      if (i == 0) start_cyc = cyc;
      rx = bits[i / BIT];
      if (pulse_at >= 0) begin
        if (i == pulse_at)          m_ready = 1'b1;
        else if (i == pulse_at + 1) m_ready = 1'b0;
      end
    end
    @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check("rst_valid", m_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_data", m_data, 0);
    check("rst_flags", {m_parity_err, m_frame_err}, 0);
    check("rst_overrun", overrun, 0);
    check("rst_break", break_det, 0);
    rst = 1'b0;
    idle(20);

    // even parity, 0xA5 has four ones -> parity bit 0
    parity_mode = 2'd1;
    two_stop    = 1'b0;
    exp_q.push_back({8'hA5, 1'b0, 1'b0});
    send(fr(8'hA5, 1, 1'b0, 1'b1, 1'b1), 11, -1);
    idle(BIT);
    // push at tick 16*10+9 of the frame: 13+10*169 clocks after start
    check("a5_valid_cycle", rise_cyc, start_cyc + 1703);

    // odd parity on 0x01: expected parity bit 0
    parity_mode = 2'd2;
    exp_q.push_back({8'h01, 1'b1, 1'b0});
    send(fr(8'h01, 1, 1'b1, 1'b1, 1'b1), 11, -1);
    idle(BIT);
    exp_q.push_back({8'h01, 1'b0, 1'b0});
    send(fr(8'h01, 1, 1'b0, 1'b1, 1'b1), 11, -1);
    idle(BIT);

    // two stop bits, second one low
    parity_mode = 2'd0;
    two_stop    = 1'b1;
    exp_q.push_back({8'h3C, 1'b0, 1'b1});
    send(fr(8'h3C, 0, 1'b0, 1'b1, 1'b0), 11, -1);
    idle(BIT);
    two_stop = 1'b0;

    // fill FIFO with the consumer stalled
    m_ready = 1'b0;
    exp_q.push_back({8'h11, 2'b00});
    send(fr(8'h11, 0, 1'b0, 1'b1, 1'b1), 10, -1);
    exp_q.push_back({8'h22, 2'b00});
    send(fr(8'h22, 0, 1'b0, 1'b1, 1'b1), 10, -1);
    exp_q.push_back({8'h33, 2'b00});
    send(fr(8'h33, 0, 1'b0, 1'b1, 1'b1), 10, -1);
    exp_q.push_back({8'h44, 2'b00});
    send(fr(8'h44, 0, 1'b0, 1'b1, 1'b1), 10, -1);
    idle(BIT);
    check("full_count", fifo_count, 4);
    check("full_head", m_data, 8'h11);
    check("no_overrun_yet", ovr_cnt, 0);
    send(fr(8'h55, 0, 1'b0, 1'b1, 1'b1), 10, -1);
    idle(BIT);
    check("overrun_pulse", ovr_cnt, 1);
    check("count_after_drop", fifo_count, 4);
    check("head_after_drop", m_data, 8'h11);

    // push while full with a pop in the same cycle (push at clock 1543)
    exp_q.push_back({8'h66, 2'b00});
    send(fr(8'h66, 0, 1'b0, 1'b1, 1'b1), 10, 1542);
    idle(BIT);
    check("swap_no_overrun", ovr_cnt, 1);
    check("swap_count", fifo_count, 4);
    check("swap_head", m_data, 8'h22);
    m_ready = 1'b1;
    idle(20);
    check("drained_count", fifo_count, 0);

    // start glitch of 4 ticks
    @(negedge clk);
    rx = 1'b0;
    idle(40);
    rx = 1'b1;
    idle(12 * BIT);
    check("glitch_count", fifo_count, 0);
    check("glitch_queue", exp_q.size(), 0);
    exp_q.push_back({8'h5A, 2'b00});
    send(fr(8'h5A, 0, 1'b0, 1'b1, 1'b1), 10, -1);
    idle(BIT);

    // line break: two frame times low
`ifndef UART_RX_BREAK_DETECT_EN
    exp_q.push_back({8'h00, 1'b0, 1'b1});
`endif
    @(negedge clk);
    rx = 1'b0;
    idle(20 * BIT);
    rx = 1'b1;
    idle(2 * BIT);
`ifdef UART_RX_BREAK_DETECT_EN
    check("break_pulse", brk_cnt, 1);
`else
    check("break_none", brk_cnt, 0);
`endif
    check("break_count", fifo_count, 0);

    for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffered.md
UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame (5..9).
REQ-002 SHALL have parameter CLOCK_FREQ, default 50_000_000, clk frequency in Hz.
REQ-003 SHALL have parameter BAUD_RATE, default 115200, line rate in bit/s.
REQ-004 SHALL have parameter OVERSAMPLE, default 16, ticks per bit (even, >=8).
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, receive words buffered (power of 2, >=2).
REQ-006 SHALL have port clk  input  1  sole clock; one clock, all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-008 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port parity_mode  input  2  0/3 none, 1 even, 2 odd; sampled only in IDLE.
REQ-010 SHALL have port two_stop  input  1  1 = two stop bits checked; sampled only in IDLE.
REQ-011 SHALL have port m_data  output  DATA_WIDTH  head-of-FIFO word.
REQ-012 SHALL have port m_parity_err  output  1  parity flag stored with head word.
REQ-013 SHALL have port m_frame_err  output  1  framing flag stored with head word.
REQ-014 SHALL have port m_valid  output  1  FIFO non-empty.
REQ-015 SHALL have port m_ready  input  1  consumer accept; pop when m_valid && m_ready.
REQ-016 SHALL have port overrun  output  1  one-clk pulse when a word is dropped.
REQ-017 SHALL have port break_det  output  1  one-clk pulse on line break.
REQ-018 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  words held.

Function
REQ-019 SHALL generate a one-clk tick enable every DIV = CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks (integer floor, min 1); divider free-runs, restarts at 0 on start-edge detection.
REQ-020 SHALL pass rx through a 2-flop synchroniser (reset value 1); all FSM decisions use the synchronised value.
REQ-021 SHALL implement FSM IDLE, START, DATA, PARITY, STOP; no other states reachable.
REQ-022 SHALL leave IDLE on a high-to-low synchronised rx edge, entering START with tick counter 0.
REQ-023 SHALL, in START at tick OVERSAMPLE/2, return to IDLE if line majority is 1 (glitch), else continue; bit boundaries thereafter every OVERSAMPLE ticks.
REQ-024 SHALL decide each bit by 2-of-3 majority of samples at ticks OVERSAMPLE/2-1, /2, /2+1 of that bit.
REQ-025 SHALL shift DATA LSB first; after DATA_WIDTH bits go to PARITY if parity enabled, else STOP.
REQ-026 SHALL set parity error when received parity != even (^data) or odd (~^data) expectation; 0 when parity disabled.
REQ-027 SHALL set frame error if any checked stop bit (1 or 2 per two_stop) samples 0.
REQ-028 SHALL push {data, parity_err, frame_err} at the mid-bit decision of the last stop bit and return to IDLE that same cycle (half-bit resync margin).
REQ-029 SHALL present a pushed word on m_valid/m_data exactly 1 clk after the push cycle when FIFO was empty.
REQ-030 SHALL, on push while full with no pop, drop the new word, keep contents, pulse overrun.
REQ-031 SHALL, on simultaneous push and pop (any occupancy, including full), perform both; no overrun; fifo_count unchanged.
REQ-032 SHALL hold m_data/flags stable while m_valid && !m_ready; preserve FIFO order; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-033 SHALL, while rst is high, force FSM IDLE, FIFO empty, m_valid 0, m_data 0, m_parity_err 0, m_frame_err 0, overrun 0, break_det 0, fifo_count 0, divider 0.
REQ-034 SHALL abandon any in-progress frame on reset; after release, reception restarts only on a fresh falling edge.

Configuration
REQ-035 SHALL honour macro UART_RX_BREAK_DETECT_EN: when defined, a frame with all data bits 0, parity bit 0 (if enabled) and frame error pulses break_det, is not pushed, and FSM stays IDLE until rx reads 1.
REQ-036 SHALL, without UART_RX_BREAK_DETECT_EN, tie break_det to 0 and push such a frame as data 0 with frame error 1.

Structure
REQ-037 SHALL place parity_mode_t enum, rx_state_t enum and rx_word_t struct {data, parity_err, frame_err} in shared package uart_pkg.
REQ-038 SHALL instantiate one sub-module, sync_fifo (parametrised width/depth, valid/ready pop, full/count outputs).

Verification (CLOCK_FREQ=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16 -> DIV=10; DATA_WIDTH=8)
REQ-039 SHALL check: even parity, send 0xA5 with parity bit 0, one stop -> m_data=0xA5, both error flags 0, m_valid 1 clk after push.
REQ-040 SHALL check: odd parity, send 0x01 with parity bit 1 -> m_parity_err=1; with parity bit 0 -> 0.
REQ-041 SHALL check: two_stop=1, second stop bit driven 0 -> m_frame_err=1, data intact.
REQ-042 SHALL check: FIFO_DEPTH=4, m_ready=0, send 0x11..0x55 -> fifo_count=4, overrun pulse at 5th push; draining yields 0x11..0x44 in order.
REQ-043 SHALL check: rx low for 4 ticks then high -> FSM back to IDLE, no push, fifo_count 0.
REQ-044 SHALL check: rx held low 2 frame times -> macro defined: one break_det pulse, no push; macro undefined: word 0x00 with m_frame_err=1.
